// File: rtl/canvas_access_arbiter.sv
// Canvas write-port arbiter: range-checked pixel draws are queued and replayed one per cycle,
// while a whole-canvas clear takes priority, flushes the queue, and waits out the canvas clear time.

module canvas_access_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLEAR_CYCLES = 2401
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       draw_valid,
    input  logic [9:0] draw_x,
    input  logic [8:0] draw_y,
    output logic       draw_ready,
    input  logic       clear_req,
    output logic       clear_done,
    output logic       mem_clear,
    output logic       mem_draw,
    output logic [9:0] mem_wx,
    output logic [8:0] mem_wy,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_START,
        CLEAR_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic            clear_pending_q, clear_pending_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      drop_count_q, drop_count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            mem_draw_q, mem_draw_d;
    logic [9:0]      mem_wx_q, mem_wx_d;
    logic [8:0]      mem_wy_q, mem_wy_d;
    logic            ready_en_q, ready_en_d;
    logic [18:0]     fifo_q [FIFO_DEPTH];

    logic            fifo_empty;
    logic            fifo_full;
    logic            accept;
    logic            in_range;
    logic            push;
    logic            pop;
    logic            flush;
    logic [18:0]     fifo_head;

    assign fifo_head = fifo_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        fifo_empty      = (wr_ptr_q == rd_ptr_q);
        fifo_full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // ready_en_q keeps draw_ready low until the first edge after reset release
        draw_ready      = ready_en_q && !fifo_full && (state_q == IDLE) && !clear_pending_q;
        accept          = draw_valid && draw_ready;
        in_range        = (draw_x <= 10'd639) && (draw_y <= 9'd479);
        push            = accept && in_range;
        pop             = (state_q == IDLE) && !clear_pending_q && !fifo_empty;
        flush           = (state_q == IDLE) && clear_pending_q;

        state_d         = state_q;
        clear_pending_d = clear_pending_q;
        cnt_d           = cnt_q;
        drop_count_d    = drop_count_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        mem_draw_d      = pop;
        mem_wx_d        = mem_wx_q;
        mem_wy_d        = mem_wy_q;
        ready_en_d      = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (accept && !in_range && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            mem_wx_d = fifo_head[18:9];
            mem_wy_d = fifo_head[8:0];
        end

        case (state_q)
            IDLE: begin
                // A draw pushed in the same cycle is still flushed here: the clear wins
                if (clear_pending_q) begin
                    rd_ptr_d        = wr_ptr_d;
                    clear_pending_d = 1'b0;
                    state_d         = CLEAR_START;
                end else if (clear_req) begin
                    clear_pending_d = 1'b1;
                end
            end
            CLEAR_START: begin
                cnt_d   = CNT_LOAD;
                state_d = CLEAR_WAIT;
            end
            CLEAR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_clear  = (state_q == CLEAR_START);
        clear_done = (state_q == CLEAR_WAIT) && (cnt_q == '0);
        busy       = (state_q != IDLE) || !fifo_empty;
        mem_draw   = mem_draw_q;
        mem_wx     = mem_wx_q;
        mem_wy     = mem_wy_q;
        drop_count = drop_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            clear_pending_q <= 1'b0;
            cnt_q           <= '0;
            drop_count_q    <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            mem_draw_q      <= 1'b0;
            mem_wx_q        <= '0;
            mem_wy_q        <= '0;
            ready_en_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            cnt_q           <= cnt_d;
            drop_count_q    <= drop_count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            mem_draw_q      <= mem_draw_d;
            mem_wx_q        <= mem_wx_d;
            mem_wy_q        <= mem_wy_d;
            ready_en_q      <= ready_en_d;
        end
    end

    // Queue storage needs no reset; the pointers define which entries are valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= {draw_x, draw_y};
        end
    end

endmodule

// File: tb/tb_canvas_access_arbiter.sv
// Directed self-checking bench for canvas_access_arbiter: draw replay, range drops,
// clear sequencing and merging, and reset in the middle of a clear.

module tb_canvas_access_arbiter;

    logic       clk;
    logic       rst;
    logic       draw_valid;
    logic [9:0] draw_x;
    logic [8:0] draw_y;
    logic       draw_ready;
    logic       clear_req;
    logic       clear_done;
    logic       mem_clear;
    logic       mem_draw;
    logic [9:0] mem_wx;
    logic [8:0] mem_wy;
    logic       busy;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    canvas_access_arbiter #(
        .FIFO_DEPTH  (4),
        .CLEAR_CYCLES(2401)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .draw_valid(draw_valid),
        .draw_x    (draw_x),
        .draw_y    (draw_y),
        .draw_ready(draw_ready),
        .clear_req (clear_req),
        .clear_done(clear_done),
        .mem_clear (mem_clear),
        .mem_draw  (mem_draw),
        .mem_wx    (mem_wx),
        .mem_wy    (mem_wy),
        .busy      (busy),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs from a negedge; returns at the next negedge after the rising edge
    task automatic applyStimulus(input logic v, input logic [9:0] x, input logic [8:0] y,
                                 input logic c);
        draw_valid = v;
        draw_x     = x;
        draw_y     = y;
        clear_req  = c;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [18:0] exp_q[$];
    int          cnt_draw;
    int          cnt_clear;
    int          cnt_done;
    int          cnt_notready;
    int          cyc;
    int          done_seen;
    int          clear_idx;
    int          done_idx;
    logic [9:0]  px;
    logic [8:0]  py;

    initial begin
        rst        = 1'b0;
        draw_valid = 1'b0;
        draw_x     = '0;
        draw_y     = '0;
        clear_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_draw_ready", draw_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_draw", mem_draw, 0);
        checkOutput("rst_mem_clear", mem_clear, 0);
        checkOutput("rst_mem_wx", mem_wx, 0);
        checkOutput("rst_mem_wy", mem_wy, 0);
        checkOutput("rst_clear_done", clear_done, 0);
        checkOutput("rst_drop_count", drop_count, 0);

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("rel_draw_ready", draw_ready, 1);

        $display("[TB] back-to-back draws");
        applyStimulus(1, 10'd10, 9'd20, 0);
        checkOutput("t1_no_draw_yet", mem_draw, 0);
        checkOutput("t1_busy_queued", busy, 1);
        applyStimulus(1, 10'd639, 9'd479, 0);
        checkOutput("t1_d0_valid", mem_draw, 1);
        checkOutput("t1_d0_x", mem_wx, 10);
        checkOutput("t1_d0_y", mem_wy, 20);
        applyStimulus(1, 10'd0, 9'd0, 0);
        checkOutput("t1_d1_valid", mem_draw, 1);
        checkOutput("t1_d1_x", mem_wx, 639);
        checkOutput("t1_d1_y", mem_wy, 479);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_d2_valid", mem_draw, 1);
        checkOutput("t1_d2_x", mem_wx, 0);
        checkOutput("t1_d2_y", mem_wy, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_after_idle", mem_draw, 0);
        checkOutput("t1_busy_idle", busy, 0);

        $display("[TB] out-of-range drops");
        applyStimulus(1, 10'd640, 9'd5, 0);
        checkOutput("t2_drop1", drop_count, 1);
        applyStimulus(1, 10'd5, 9'd480, 0);
        checkOutput("t2_drop2", drop_count, 2);
        checkOutput("t2_no_draw_a", mem_draw, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_no_draw_b", mem_draw, 0);
        checkOutput("t2_busy", busy, 0);
        cnt_draw = 0;
        for (int i = 0; i < 252; i++) begin
            if (i % 2 == 0) applyStimulus(1, 10'd1023, 9'd0, 0);
            else            applyStimulus(1, 10'd0, 9'd511, 0);
            cnt_draw += int'(mem_draw);
        end
        checkOutput("t2_drop254", drop_count, 254);
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1, 10'd700, 9'd300, 0);
            cnt_draw += int'(mem_draw);
        end
        checkOutput("t2_drop_sat", drop_count, 255);
        checkOutput("t2_bad_draws", cnt_draw, 0);

        $display("[TB] sustained draw stream");
        cnt_draw     = 0;
        cnt_notready = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                px = 10'(i * 70 + 3);
                py = 9'(i * 50 + 1);
                if (!draw_ready) cnt_notready++;
                exp_q.push_back({px, py});
                applyStimulus(1, px, py, 0);
            end else begin
                applyStimulus(0, 0, 0, 0);
            end
            if (mem_draw) begin
                cnt_draw++;
                if (exp_q.size() == 0) checkOutput("t3_extra_draw", 1, 0);
                else checkOutput("t3_draw_order", {13'd0, mem_wx, mem_wy}, {13'd0, exp_q.pop_front()});
            end
        end
        checkOutput("t3_ready_held", cnt_notready, 0);
        checkOutput("t3_draw_count", cnt_draw, 8);
        checkOutput("t3_queue_drained", exp_q.size(), 0);
        checkOutput("t3_hold_x", mem_wx, 493);
        checkOutput("t3_hold_y", mem_wy, 351);

        $display("[TB] clear with draws in flight");
        applyStimulus(1, 10'd11, 9'd1, 0);
        applyStimulus(1, 10'd12, 9'd2, 0);
        applyStimulus(1, 10'd13, 9'd3, 0);
        applyStimulus(1, 10'd14, 9'd4, 1);
        checkOutput("t4_last_draw_x", mem_wx, 13);
        checkOutput("t4_ready_pending", draw_ready, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_mem_clear", mem_clear, 1);
        checkOutput("t4_no_draw_start", mem_draw, 0);
        checkOutput("t4_busy", busy, 1);
        cyc          = 0;
        done_seen    = 0;
        cnt_draw     = 0;
        cnt_clear    = 0;
        cnt_notready = 0;
        while (cyc < 3000) begin
            cnt_notready += int'(draw_ready);
            applyStimulus(0, 0, 0, 0);
            cyc++;
            cnt_draw  += int'(mem_draw);
            cnt_clear += int'(mem_clear);
            if (clear_done) begin
                done_seen = 1;
                break;
            end
        end
        checkOutput("t4_done_seen", done_seen, 1);
        checkOutput("t4_done_latency", cyc, 2401);
        checkOutput("t4_draws_during", cnt_draw, 0);
        checkOutput("t4_extra_clear", cnt_clear, 0);
        checkOutput("t4_ready_during", cnt_notready, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_done_pulse", clear_done, 0);
        checkOutput("t4_ready_back", draw_ready, 1);
        checkOutput("t4_busy_back", busy, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_flushed_no_draw", mem_draw, 0);

        $display("[TB] repeated clear request merges");
        cnt_clear = 0;
        cnt_done  = 0;
        clear_idx = -1;
        done_idx  = -1;
        for (int i = 0; i < 2600; i++) begin
            applyStimulus(0, 0, 0, (i == 0) || (i == 100));
            if (mem_clear) begin
                cnt_clear++;
                clear_idx = i;
            end
            if (clear_done) begin
                cnt_done++;
                done_idx = i;
            end
        end
        checkOutput("t5_single_clear", cnt_clear, 1);
        checkOutput("t5_single_done", cnt_done, 1);
        checkOutput("t5_clear_at", clear_idx, 1);
        checkOutput("t5_done_at", done_idx, 2402);
        checkOutput("t5_idle_busy", busy, 0);

        $display("[TB] reset during clear");
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 1402; i++) begin
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("t6_in_wait_busy", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_ready", draw_ready, 0);
        checkOutput("t6_rst_done", clear_done, 0);
        checkOutput("t6_rst_clear", mem_clear, 0);
        checkOutput("t6_rst_wx", mem_wx, 0);
        checkOutput("t6_rst_wy", mem_wy, 0);
        checkOutput("t6_rst_drop", drop_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt_done  = 0;
        cnt_clear = 0;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(0, 0, 0, 0);
            cnt_done  += int'(clear_done);
            cnt_clear += int'(mem_clear);
        end
        checkOutput("t6_no_done", cnt_done, 0);
        checkOutput("t6_no_clear", cnt_clear, 0);
        checkOutput("t6_ready_after", draw_ready, 1);
        applyStimulus(1, 10'd100, 9'd200, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t6_draw_valid", mem_draw, 1);
        checkOutput("t6_draw_x", mem_wx, 100);
        checkOutput("t6_draw_y", mem_wy, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
